// File: rtl/coffee_pkg.sv
// Shared coffee tank definitions: state encoding, level width and thresholds.
// The route controller uses the same FULL_LEVEL/HALF_LEVEL so both ends agree.
// Also provides the divider width helper used by the tank top.
package coffee_pkg;

  localparam int LEVEL_W    = 8;
  localparam int FULL_LEVEL = 100;
  localparam int HALF_LEVEL = 50;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    POUR = 2'b10
  } state_e;

  // Divider must hold the larger of the two rates, plus one bit of headroom.
  function automatic int div_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/coffee_tank_rate_tick.sv
// Loadable modulo-N counter: emits a 1-cycle tick on the cycle the count is N-1.
// Latency: tick is combinational from the count; the count wraps to 0 after a tick.
// Synchronous clear has priority over counting; no backpressure.
module rate_tick #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] n,
  output logic         tick
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = en && (cnt_q == (n - ONE));

  // Next count: clear wins, otherwise advance and wrap on the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : (cnt_q + ONE);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/coffee_tank.sv
// Coffee tank model: fills while docked, pours cups on a request/ack handshake.
// Latency: CupAck lands CUP_SIZE*POUR_DIV edges after entering POUR; all outputs registered.
// A request is answered exactly once (Ack or Deny); it must drop low before it is honoured again.
module coffee_tank #(
  parameter int FULL_LEVEL = coffee_pkg::FULL_LEVEL,
  parameter int CUP_SIZE   = 5,
  parameter int FILL_DIV   = 4,
  parameter int POUR_DIV   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           FillEn,
  input  logic                           CupReq,
  output logic                           CupAck,
  output logic                           CupDeny,
  output logic [coffee_pkg::LEVEL_W-1:0] CoffeeLevel,
  output logic                           Full,
  output logic                           Empty,
  output logic                           Pouring
);

  import coffee_pkg::*;

  localparam int DIV_W = div_width(FILL_DIV, POUR_DIV);

  localparam logic [LEVEL_W-1:0] ONE_L     = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] FULL_L    = LEVEL_W'(FULL_LEVEL);
  localparam logic [LEVEL_W-1:0] FULL_LAST = LEVEL_W'(FULL_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] CUP_L     = LEVEL_W'(CUP_SIZE);
  localparam logic [LEVEL_W-1:0] CUP_LAST  = LEVEL_W'(CUP_SIZE - 1);
  localparam logic [DIV_W-1:0]   FILL_N    = DIV_W'(FILL_DIV);
  localparam logic [DIV_W-1:0]   POUR_N    = DIV_W'(POUR_DIV);

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] cup_q, cup_d;
  logic               armed_q, armed_d;
  logic               ack_q, ack_d;
  logic               deny_q, deny_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;

  logic               tick;
  logic [DIV_W-1:0]   div_n;
  logic               div_en;
  logic               div_clr;

  // Divider is held at zero in IDLE so every FILL/POUR starts on a fresh period.
  assign div_n   = (state_q == FILL) ? FILL_N : POUR_N;
  assign div_en  = ((state_q == FILL) && FillEn) || (state_q == POUR);
  assign div_clr = (state_q == IDLE);

  rate_tick #(
    .W (DIV_W)
  ) u_rate_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .en    (div_en),
    .n     (div_n),
    .tick  (tick)
  );

  // Next-state, level and handshake pulses; fill has priority over a pending cup.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cup_d   = cup_q;
    ack_d   = 1'b0;
    deny_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (FillEn && (level_q < FULL_L)) begin
          state_d = FILL;
        end else if (CupReq && armed_q) begin
          if (level_q >= CUP_L) begin
            state_d = POUR;
            cup_d   = '0;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (!FillEn) begin
          state_d = IDLE;
        end else if (tick) begin
          level_d = level_q + ONE_L;
          if (level_q == FULL_LAST) begin
            state_d = IDLE;
          end
        end
      end
      POUR: begin
        if (tick) begin
          level_d = level_q - ONE_L;
          cup_d   = cup_q + ONE_L;
          if (cup_q == CUP_LAST) begin
            ack_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Re-arm only once the requester lets go; a served or refused request disarms.
    if (!CupReq) begin
      armed_d = 1'b1;
    end else if (ack_d || deny_d) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end

    full_d  = (level_d == FULL_L);
    empty_d = (level_d == '0);
  end

  // State and registered outputs; reset abandons any fill or pour in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      cup_q   <= '0;
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
      deny_q  <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cup_q   <= cup_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
      deny_q  <= deny_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign CupAck      = ack_q;
  assign CupDeny     = deny_q;
  assign CoffeeLevel = level_q;
  assign Full        = full_q;
  assign Empty       = empty_q;
  assign Pouring     = (state_q == POUR);

endmodule

// File: tb/tb_coffee_tank.sv
// Bench for coffee_tank: directed test plan followed by a randomized soak.
// Every cycle the DUT outputs are compared with a cycle-level behavioural model.
// Expected values come only from the model and from constants of the tank's rules.
module tb_coffee_tank;

  localparam int FULL = 100;
  localparam int CUP  = 5;
  localparam int FDIV = 4;
  localparam int PDIV = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fill_en = 1'b0;
  logic       cup_req = 1'b0;
  logic       cup_ack;
  logic       cup_deny;
  logic [7:0] coffee_level;
  logic       full;
  logic       empty;
  logic       pouring;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0 idle, 1 filling, 2 pouring; elapsed counts cycles since a step.
  int m_mode    = 0;
  int m_level   = 0;
  int m_elapsed = 0;
  int m_poured  = 0;
  bit m_armed   = 1'b1;
  bit m_ack     = 1'b0;
  bit m_deny    = 1'b0;

  always #5 clk = ~clk;

  coffee_tank #(
    .FULL_LEVEL (FULL),
    .CUP_SIZE   (CUP),
    .FILL_DIV   (FDIV),
    .POUR_DIV   (PDIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .FillEn      (fill_en),
    .CupReq      (cup_req),
    .CupAck      (cup_ack),
    .CupDeny     (cup_deny),
    .CoffeeLevel (coffee_level),
    .Full        (full),
    .Empty       (empty),
    .Pouring     (pouring)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge of the tank's rules, applied to the inputs present at that edge.
  task automatic model_edge();
    bit served;
    bit refused;
    m_ack  = 1'b0;
    m_deny = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_level = 0; m_elapsed = 0; m_poured = 0; m_armed = 1'b1;
      return;
    end
    served  = 1'b0;
    refused = 1'b0;
    if (m_mode == 0) begin
      if (fill_en && m_level < FULL) begin
        m_mode = 1; m_elapsed = 0;
      end else if (cup_req && m_armed) begin
        if (m_level >= CUP) begin
          m_mode = 2; m_elapsed = 0; m_poured = 0;
        end else begin
          refused = 1'b1;
        end
      end
    end else if (m_mode == 1) begin
      if (!fill_en) begin
        m_mode = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == FDIV) begin
          m_elapsed = 0;
          m_level++;
          if (m_level == FULL) m_mode = 0;
        end
      end
    end else begin
      m_elapsed++;
      if (m_elapsed == PDIV) begin
        m_elapsed = 0;
        m_level--;
        m_poured++;
        if (m_poured == CUP) begin
          served = 1'b1;
          m_mode = 0;
        end
      end
    end
    if (!cup_req) m_armed = 1'b1;
    else if (served || refused) m_armed = 1'b0;
    m_ack  = served;
    m_deny = refused;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("level",   int'(coffee_level), m_level);
    check_eq("ack",     int'(cup_ack),      int'(m_ack));
    check_eq("deny",    int'(cup_deny),     int'(m_deny));
    check_eq("full",    int'(full),         (m_level == FULL) ? 1 : 0);
    check_eq("empty",   int'(empty),        (m_level == 0) ? 1 : 0);
    check_eq("pouring", int'(pouring),      (m_mode == 2) ? 1 : 0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) step();
    rst_n = 1'b1;
  endtask

  // Fill from the current level up to target, then undock and let FILL exit.
  task automatic fill_to(input int target);
    int guard;
    guard = 0;
    fill_en = 1'b1;
    while (int'(coffee_level) != target && guard < 1000) begin
      step();
      guard++;
    end
    check_eq("fill_to_reach", int'(coffee_level), target);
    fill_en = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int acks;
    int denies;

    // 1. Reset
    do_reset(2);
    step();
    check_eq("rst_level", int'(coffee_level), 0);
    check_eq("rst_empty", int'(empty), 1);
    check_eq("rst_full",  int'(full), 0);
    check_eq("rst_pour",  int'(pouring), 0);

    // 2. Full fill from 0, then stay full with FillEn still high
    fill_en = 1'b1;
    n = 0;
    while (!full && n < 600) begin
      step();
      n++;
    end
    check_eq("fill_cycles_in_fill", n - 1, FULL * FDIV);
    check_eq("fill_full_level", int'(coffee_level), FULL);
    for (int i = 0; i < 20; i++) step();
    check_eq("fill_hold_level", int'(coffee_level), FULL);
    fill_en = 1'b0;
    step();

    // 3. Cup serve from 100
    cup_req = 1'b1;
    step();
    n = 1;
    check_eq("pour_start", int'(pouring), 1);
    while (!cup_ack && n < 50) begin
      step();
      n++;
    end
    check_eq("pour_ack_edges", n, 1 + CUP * PDIV);
    check_eq("pour_ack_level", int'(coffee_level), FULL - CUP);
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (cup_ack) acks++;
    end
    check_eq("pour_no_second_ack", acks, 0);
    cup_req = 1'b0;
    step();

    // 4. Deny at level 3, once per request assertion
    do_reset(2);
    fill_to(3);
    denies = 0;
    cup_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cup_deny) denies++;
    end
    check_eq("deny_first", denies, 1);
    check_eq("deny_level", int'(coffee_level), 3);
    cup_req = 1'b0;
    step();
    cup_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cup_deny) denies++;
    end
    check_eq("deny_second", denies, 2);
    cup_req = 1'b0;
    step();

    // 5. Simultaneous fill and cup request at level 50
    do_reset(2);
    fill_to(50);
    fill_en = 1'b1;
    cup_req = 1'b1;
    step();
    check_eq("simul_not_pouring", int'(pouring), 0);
    n = 0;
    while (int'(coffee_level) != 60 && n < 100) begin
      step();
      n++;
    end
    check_eq("simul_reach_60", int'(coffee_level), 60);
    fill_en = 1'b0;
    n = 0;
    while (!cup_ack && n < 40) begin
      step();
      n++;
    end
    check_eq("simul_ack_seen", int'(cup_ack), 1);
    check_eq("simul_ack_level", int'(coffee_level), 55);
    cup_req = 1'b0;
    step();

    // 6. Reset three cycles into a pour from 80
    do_reset(2);
    fill_to(80);
    cup_req = 1'b1;
    step();
    check_eq("rstpour_start", int'(pouring), 1);
    for (int i = 0; i < 3; i++) step();
    acks = 0;
    rst_n = 1'b0;
    step();
    if (cup_ack) acks++;
    rst_n = 1'b1;
    cup_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cup_ack) acks++;
    end
    check_eq("rstpour_level", int'(coffee_level), 0);
    check_eq("rstpour_pouring", int'(pouring), 0);
    check_eq("rstpour_no_ack", acks, 0);

    // Randomized soak against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) fill_en = ~fill_en;
      if ($urandom_range(0, 7) == 0) cup_req = ~cup_req;
      rst_n = ($urandom_range(0, 599) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
